// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data load/store.
// Data wins by default. A starved fetch is forced through unless a split data access holds the lock.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned RD_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_we,
    input  logic        data_lock,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_starve_cnt;
    logic          r_lock_q;
    logic          w_starved;
    logic          w_fetch_gnt;
    logic          w_data_gnt;
    logic          w_data_rd;

    // One-hot pending-read owner per pipeline stage; the last stage lines up with mem_rdata.
    logic r_pend_f [RD_LATENCY];
    logic r_pend_d [RD_LATENCY];

    always_comb begin
        w_fetch_gnt = 1'b0;
        w_data_gnt  = 1'b0;
        w_starved   = fetch_req && (r_starve_cnt == LIMIT) && !r_lock_q;
        if (rst_n && !halt) begin
            if (w_starved) begin
                w_fetch_gnt = 1'b1;
            end else begin
                w_data_gnt  = data_req;
                w_fetch_gnt = fetch_req && !data_req;
            end
        end
    end

    assign w_data_rd = w_data_gnt && (data_we == 4'b0000);
    assign fetch_gnt = w_fetch_gnt;
    assign data_gnt  = w_data_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        mem_re    = 1'b0;
        if (w_data_gnt) begin
            mem_addr  = data_addr;
            mem_we    = data_we;
            mem_wdata = (data_we != 4'b0000) ? data_wdata : '0;
            mem_re    = (data_we == 4'b0000);
        end else if (w_fetch_gnt) begin
            mem_addr = fetch_addr;
            mem_re   = 1'b1;
        end
    end

    // Halt freezes both the starvation count and the lock so arbitration resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_lock_q     <= 1'b0;
        end else if (!halt) begin
            if (!fetch_req || w_fetch_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            if (w_data_gnt) begin
                r_lock_q <= data_lock;
            end else if (!data_req) begin
                r_lock_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_f[0] <= 1'b0;
            r_pend_d[0] <= 1'b0;
        end else begin
            r_pend_f[0] <= w_fetch_gnt;
            r_pend_d[0] <= w_data_rd;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < RD_LATENCY; gi++) begin : g_pend
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pend_f[gi] <= 1'b0;
                    r_pend_d[gi] <= 1'b0;
                end else begin
                    r_pend_f[gi] <= r_pend_f[gi-1];
                    r_pend_d[gi] <= r_pend_d[gi-1];
                end
            end
        end
    endgenerate

    assign fetch_rvalid = r_pend_f[RD_LATENCY-1];
    assign data_rvalid  = r_pend_d[RD_LATENCY-1];
    assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
    assign data_rdata   = data_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        data_req = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_we = '0;
    logic        data_lock = 1'b0;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: starvation count, lock flag, owner of the read issued last cycle (0 none, 1 fetch, 2 data).
    int m_starve = 0;
    bit m_lock = 1'b0;
    int m_pend = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_we(data_we), .data_lock(data_lock), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Who gets the port this cycle: 0 none, 1 fetch, 2 data.
    function automatic int pick();
        if (!rst_n || halt) return 0;
        if (fetch_req && m_starve >= LIMIT && !m_lock) return 1;
        if (data_req) return 2;
        if (fetch_req) return 1;
        return 0;
    endfunction

    function automatic logic [136:0] exp_vec();
        int          w;
        logic [31:0] a, wd, frd, drd;
        logic [3:0]  we;
        logic        re, frv, drv;
        w   = pick();
        a   = (w == 1) ? fetch_addr : ((w == 2) ? data_addr : 32'h0);
        we  = (w == 2) ? data_we : 4'h0;
        wd  = (w == 2 && data_we != 4'h0) ? data_wdata : 32'h0;
        re  = (w == 1) || (w == 2 && data_we == 4'h0);
        frv = (m_pend == 1);
        drv = (m_pend == 2);
        frd = frv ? mem_rdata : 32'h0;
        drd = drv ? mem_rdata : 32'h0;
        return {w == 1, w == 2, a, wd, we, re, frv, frd, drv, drd};
    endfunction

    function automatic logic [136:0] dut_vec();
        return {fetch_gnt, data_gnt, mem_addr, mem_wdata, mem_we, mem_re,
                fetch_rvalid, fetch_rdata, data_rvalid, data_rdata};
    endfunction

    // Advance the model across the coming rising edge using the inputs currently applied.
    task automatic commit();
        int w;
        bit rd;
        w  = pick();
        rd = (w == 1) || (w == 2 && data_we == 4'h0);
        if (rst_n && !halt) begin
            if (fetch_req && w != 1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else m_starve = 0;
            if (w == 2) m_lock = data_lock;
            else if (!data_req) m_lock = 1'b0;
        end
        m_pend = (rst_n && rd) ? w : 0;
    endtask

    task automatic model_reset();
        m_starve = 0;
        m_lock   = 1'b0;
        m_pend   = 0;
    endtask

    task automatic drive(input bit fr, input logic [31:0] fa, input bit dr, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] we, input bit dl, input bit h,
                         input logic [31:0] md);
        fetch_req = fr; fetch_addr = fa; data_req = dr; data_addr = da;
        data_wdata = wd; data_we = we; data_lock = dl; halt = h; mem_rdata = md;
    endtask

    task automatic next_cycle();
        commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
        next_cycle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1, 32'h40, 1, 32'h80, 0, 0, 0, 0, 32'h1234);
        #1;
        n_vec++;
        if ({fetch_gnt, data_gnt, mem_re, mem_addr, fetch_rvalid, data_rvalid} !== 38'h0) begin
            n_err++;
            $display("FAIL reset_outputs got gnt=%b%b re=%b addr=%h rv=%b%b required all zero",
                     fetch_gnt, data_gnt, mem_re, mem_addr, fetch_rvalid, data_rvalid);
        end
        n_vec++;
        if (dut.r_starve_cnt !== 3'd0 || dut.r_lock_q !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got starve=%0d lock=%b required 0 0", dut.r_starve_cnt, dut.r_lock_q);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(0, 0, 1, 32'h80, 0, 0, 0, 0, 32'h1234);
        #1;
        n_vec++;
        if (data_gnt !== 1'b1 || mem_addr !== 32'h80 || dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL first_grant got dgnt=%b addr=%h vec=%h required dgnt=1 addr=00000080 vec=%h",
                     data_gnt, mem_addr, dut_vec(), exp_vec());
        end
        $display("txn reset: first grant data addr=%h", mem_addr);
        next_cycle();
        idle_cycle();
    endtask

    task automatic test_fetch_read();
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, $urandom);
        #1;
        n_vec++;
        if (fetch_gnt !== 1'b1 || data_gnt !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL fetch_issue got fgnt=%b dgnt=%b re=%b addr=%h required 1 0 1 00000100",
                     fetch_gnt, data_gnt, mem_re, mem_addr);
        end
        $display("txn fetch read issue addr=%h", mem_addr);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        #1;
        n_vec++;
        if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hDEADBEEF || data_rvalid !== 1'b0 || data_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL fetch_return got frv=%b frd=%h drv=%b drd=%h required 1 deadbeef 0 00000000",
                     fetch_rvalid, fetch_rdata, data_rvalid, data_rdata);
        end
        $display("txn fetch read return data=%h", fetch_rdata);
        next_cycle();
        idle_cycle();
    endtask

    task automatic test_starvation();
        int exp_who [6] = '{2, 2, 2, 2, 1, 2};
        for (int c = 0; c < 6; c++) begin
            drive(1, 32'h1000 + c * 4, 1, 32'h2000 + c * 4, 0, 0, 0, 0, $urandom);
            #1;
            n_vec++;
            if (int'({data_gnt, fetch_gnt}) !== exp_who[c] || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL starve_grant cyc=%0d got who=%0d vec=%h required who=%0d vec=%h",
                         c, {data_gnt, fetch_gnt}, dut_vec(), exp_who[c], exp_vec());
            end
            if (c >= 1) begin
                n_vec++;
                if ({fetch_rvalid, data_rvalid} !== ((c == 5) ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL starve_order cyc=%0d got rv=%b%b", c, fetch_rvalid, data_rvalid);
                end
            end
            if (c == 5) begin
                n_vec++;
                if (dut.r_starve_cnt !== 3'd0) begin
                    n_err++;
                    $display("FAIL starve_clear got starve=%0d required 0", dut.r_starve_cnt);
                end
            end
            $display("txn starve cyc=%0d grant=%s addr=%h", c, fetch_gnt ? "fetch" : "data", mem_addr);
            next_cycle();
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_locked_store();
        int exp_who [6] = '{2, 2, 2, 2, 2, 1};
        for (int c = 0; c < 6; c++) begin
            if (c == 3)      drive(1, 32'h500, 1, 32'h203, 32'hAB000000, 4'b1000, 1, 0, $urandom);
            else if (c == 4) drive(1, 32'h500, 1, 32'h204, 32'h00CDEF12, 4'b0111, 0, 0, $urandom);
            else             drive(1, 32'h500, 1, 32'h600 + c, 0, 0, 0, 0, $urandom);
            #1;
            n_vec++;
            if (int'({data_gnt, fetch_gnt}) !== exp_who[c] || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL lock_grant cyc=%0d got who=%0d vec=%h required who=%0d vec=%h",
                         c, {data_gnt, fetch_gnt}, dut_vec(), exp_who[c], exp_vec());
            end
            if (c == 3) begin
                n_vec++;
                if ({mem_addr, mem_we, mem_wdata, mem_re} !== {32'h203, 4'b1000, 32'hAB000000, 1'b0}) begin
                    n_err++;
                    $display("FAIL lock_store got addr=%h we=%b wd=%h re=%b required 00000203 1000 ab000000 0",
                             mem_addr, mem_we, mem_wdata, mem_re);
                end
            end
            if (c == 4) begin
                n_vec++;
                if (int'(dut.r_starve_cnt) !== LIMIT || mem_we !== 4'b0111) begin
                    n_err++;
                    $display("FAIL lock_hold got starve=%0d we=%b required %0d 0111", dut.r_starve_cnt, mem_we, LIMIT);
                end
            end
            if (c >= 4) begin
                n_vec++;
                if ({fetch_rvalid, data_rvalid} !== 2'b00) begin
                    n_err++;
                    $display("FAIL lock_no_rvalid cyc=%0d got rv=%b%b required 00", c, fetch_rvalid, data_rvalid);
                end
            end
            $display("txn lock cyc=%0d grant=%s addr=%h we=%b", c, fetch_gnt ? "fetch" : "data", mem_addr, mem_we);
            next_cycle();
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_halt();
        int exp_who [4] = '{2, 0, 0, 2};
        bit h;
        for (int c = 0; c < 4; c++) begin
            h = (c == 1 || c == 2);
            drive(1, 32'h700, 1, 32'h300, 0, 0, 0, h, (c == 1) ? 32'hCAFEF00D : $urandom);
            #1;
            n_vec++;
            if (int'({data_gnt, fetch_gnt}) !== exp_who[c] || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL halt_grant cyc=%0d got who=%0d vec=%h required who=%0d vec=%h",
                         c, {data_gnt, fetch_gnt}, dut_vec(), exp_who[c], exp_vec());
            end
            if (c == 1) begin
                n_vec++;
                if (data_rvalid !== 1'b1 || data_rdata !== 32'hCAFEF00D || mem_re !== 1'b0) begin
                    n_err++;
                    $display("FAIL halt_return got drv=%b drd=%h re=%b required 1 cafef00d 0",
                             data_rvalid, data_rdata, mem_re);
                end
            end
            if (c == 2) begin
                n_vec++;
                if (dut.r_starve_cnt !== 3'd1 || data_rvalid !== 1'b0) begin
                    n_err++;
                    $display("FAIL halt_freeze got starve=%0d drv=%b required 1 0", dut.r_starve_cnt, data_rvalid);
                end
            end
            $display("txn halt cyc=%0d halt=%b who=%0d", c, h, {data_gnt, fetch_gnt});
            next_cycle();
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_reset_inflight();
        drive(1, 32'h800, 1, 32'h900, 0, 0, 0, 0, $urandom);
        #1;
        n_vec++;
        if (data_gnt !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL rst_issue got vec=%h required vec=%h", dut_vec(), exp_vec());
        end
        $display("txn reset-in-flight issue data read addr=%h", mem_addr);
        commit();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({fetch_rvalid, data_rvalid, fetch_gnt, data_gnt} !== 4'b0 || data_rdata !== 32'h0 || dut.r_starve_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL rst_async got rv=%b%b gnt=%b%b drd=%h starve=%0d required all zero",
                     fetch_rvalid, data_rvalid, fetch_gnt, data_gnt, data_rdata, dut.r_starve_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
            #1;
            n_vec++;
            if ({fetch_rvalid, data_rvalid} !== 2'b00 || dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rst_discard cyc=%0d got rv=%b%b vec=%h required rv=00 vec=%h",
                         c, fetch_rvalid, data_rvalid, dut_vec(), exp_vec());
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom, $urandom,
                  ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom);
            #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h required=%h", c, dut_vec(), exp_vec());
            end
            if (fetch_gnt || data_gnt)
                $display("txn random cyc=%0d grant=%s addr=%h we=%b", c, fetch_gnt ? "fetch" : "data", mem_addr, mem_we);
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_starvation();
        test_locked_store();
        test_halt();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles fetch may be refused before it is forced through.
REQ-002 SHALL have parameter RD_LATENCY, fixed at 1: memory returns read data one cycle after issue.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 halt  in  1  freezes granting; an in-flight read still returns.
REQ-006 fetch_req  in  1  fetch port requests a 32-bit read.
REQ-007 fetch_addr  in  32  fetch read address.
REQ-008 fetch_gnt  out  1  fetch request issued this cycle (combinational).
REQ-009 fetch_rvalid  out  1  fetch read data valid (registered).
REQ-010 fetch_rdata  out  32  fetch read data.
REQ-011 data_req  in  1  execute-stage load/store request.
REQ-012 data_addr  in  32  data address.
REQ-013 data_wdata  in  32  store data, already lane-shifted.
REQ-014 data_we  in  4  byte write enables; 4'b0000 means read.
REQ-015 data_lock  in  1  second half of a misaligned split follows; hold priority for data.
REQ-016 data_gnt  out  1  data request issued this cycle (combinational).
REQ-017 data_rvalid  out  1  data read data valid (registered).
REQ-018 data_rdata  out  32  data read data.
REQ-019 mem_addr  out  32  shared port address.
REQ-020 mem_wdata  out  32  shared port write data.
REQ-021 mem_we  out  4  shared port byte enables.
REQ-022 mem_re  out  1  shared port read strobe.
REQ-023 mem_rdata  in  32  memory read data, valid RD_LATENCY cycles after mem_re.

Function
REQ-024 At most one of fetch_gnt/data_gnt SHALL be high per cycle; both low when halt=1 or rst_n=0.
REQ-025 Default priority: data over fetch; data_gnt=data_req, fetch_gnt=fetch_req&&!data_req.
REQ-026 starve_cnt (width ceil(log2(STARVE_LIMIT+1))): +1 each cycle fetch_req=1 and fetch_gnt=0; cleared on fetch_gnt or fetch_req=0; saturates at STARVE_LIMIT.
REQ-027 When starve_cnt==STARVE_LIMIT and fetch_req=1, fetch SHALL be granted over data, unless lock_q=1.
REQ-028 lock_q SHALL set on a cycle with data_gnt && data_lock, clear on the next data_gnt without data_lock or when data_req drops; while set, data holds priority regardless of starve_cnt.
REQ-029 Granted port drives mem_addr; mem_wdata/mem_we from data port only on data write grant, else 0; mem_re=1 on fetch grant or data grant with data_we==0.
REQ-030 No grant: mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
REQ-031 Read issue cycle SHALL record pend_valid=1, pend_owner (0=fetch,1=data); next cycle owner's rvalid=1 with rdata=mem_rdata; other port's rvalid=0 and rdata=0.
REQ-032 Writes SHALL produce no rvalid.
REQ-033 Back-to-back reads each cycle SHALL produce rvalid every cycle, owners in issue order.
REQ-034 halt=1: no new grants, starve_cnt and lock_q hold, pending read still delivered.
REQ-035 Simultaneous data_lock and starvation limit: lock wins; fetch granted first cycle lock_q clears with fetch_req=1.

Reset
REQ-036 rst_n=0 SHALL asynchronously clear starve_cnt, lock_q, pend_valid, pend_owner, both rvalid, both rdata.
REQ-037 A read in flight at reset SHALL be discarded; no rvalid after rst_n rises.
REQ-038 First grant possible in the first cycle with rst_n=1.

Verification
REQ-039 fetch_req=1 addr 0x100, data idle, mem_rdata=0xDEADBEEF -> fetch_gnt=1, mem_re=1, next cycle fetch_rvalid=1, fetch_rdata=0xDEADBEEF.
REQ-040 Both request continuously, data reads, STARVE_LIMIT=4 -> data granted cycles 0-3, fetch granted cycle 4, starve_cnt back to 0, data granted cycle 5.
REQ-041 Data store addr 0x203 we=4'b1000 wdata=0xAB000000 with data_lock=1, then 0x204 we=4'b0111 -> two consecutive data grants, no fetch grant between even at starve limit, no rvalid.
REQ-042 Data read issued, halt=1 next cycle -> data_rvalid=1 that cycle, no grants while halt, grants resume after halt=0.
REQ-043 Read issued, rst_n pulled low mid-cycle -> rvalid outputs 0 immediately, none after release, starve_cnt=0.
